// File: rtl/hcu_pkg.sv
// Shared types and helpers for the hazard control unit.
//   hcu_state_t   : sequencer states (IDLE, LOAD_STALL, FLUSH, BR_WAIT)
//   timer_width() : width of the shared down-counter for a parameter set
//   params_legal(): elaboration-time sanity check of the top parameters
package hcu_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    BR_WAIT    = 2'd3
  } hcu_state_t;

  // Counter width: $clog2(max(cycles)+1), never narrower than one bit.
  function automatic int timer_width(input int ld_cyc, input int fl_cyc, input int br_cyc);
    int m;
    int w;
    m = ld_cyc;
    if (fl_cyc > m) m = fl_cyc;
    else m = m;
    if (br_cyc > m) m = br_cyc;
    else m = m;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_legal(input int reg_aw, input int ld_cyc, input int fl_cyc,
                                      input int br_cyc, input int cnt_w);
    return (reg_aw >= 1) && (ld_cyc >= 1) && (fl_cyc >= 1) && (br_cyc >= 0) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/hcu_stall_timer.sv
// Loadable down-counter with a zero flag, shared by every sequencer state.
//   clk, reset (async, active-low)
//   load / load_val : overwrite the count
//   dec             : decrement by one (sticks at zero)
//   zero            : count is zero
module hcu_stall_timer
  import hcu_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load has priority over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= {W{1'b0}};
    else        count_q <= count_d;
  end

  assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/hcu_param.sv
// Hazard control unit for the F/D/E/W pipeline.
//   Inputs : per-stage hazard info (load/dest/sources in E, sources in D,
//            writeback dest/enable, branch/jump in D, branch + outcome in E),
//            perf_clr (sync counter clear), reset (async, active-low).
//   Outputs: stage stalls/flushes, redirect_F, W->E forwarding selects,
//            busy (sequencer active), saturating stall_F cycle count.
// Trigger-cycle controls are combinational so the hazard is covered in the
// same cycle it is detected; the sequencer then holds them for the rest of
// the configured duration.
module hcu_param
  import hcu_pkg::*;
#(
  parameter int REG_AW             = 5,
  parameter int LOAD_STALL_CYCLES  = 2,
  parameter int LOAD_DEP_CHECK     = 1,
  parameter int FLUSH_CYCLES       = 1,
  parameter int FLUSH_W_ON_MISPRED = 1,
  parameter int BR_WAIT_CYCLES     = 1,
  parameter int CNT_W              = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              regwe_W,
  input  logic              branch_D,
  input  logic              jump_D,
  input  logic              branch_E,
  input  logic              cond_met_E,
  input  logic              perf_clr,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_W,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_W,
  output logic              redirect_F,
  output logic              fwd_a_E,
  output logic              fwd_b_E,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int TW = timer_width(LOAD_STALL_CYCLES, FLUSH_CYCLES, BR_WAIT_CYCLES);
  // Reload values: the trigger cycle already counts as one asserted cycle.
  localparam logic [TW-1:0] LS_INIT = TW'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [TW-1:0] FL_INIT = TW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [TW-1:0] BR_INIT = TW'((BR_WAIT_CYCLES > 1) ? BR_WAIT_CYCLES - 2 : 0);
  localparam logic          FW_MIS  = (FLUSH_W_ON_MISPRED != 0);

  if (!params_legal(REG_AW, LOAD_STALL_CYCLES, FLUSH_CYCLES, BR_WAIT_CYCLES, CNT_W)) begin : g_bad_params
    $error("hcu_param: illegal parameter set");
  end

  hcu_state_t       state_q, state_d;
  logic             br_done_q, br_done_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic          mispred_s, ld_haz_s, br_haz_s, dep_hit_s;
  logic          tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [TW-1:0] tmr_val_s;
  logic          stall_s, flush_de_s, flush_w_s, redirect_s;

  hcu_stall_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Hazard detection; rd_E == x0 never creates a true dependency.
  always_comb begin
    mispred_s = branch_E & ~cond_met_E;
    dep_hit_s = (rd_E != {REG_AW{1'b0}}) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    ld_haz_s  = load_E & ((LOAD_DEP_CHECK == 0) | dep_hit_s);
    br_haz_s  = (branch_D | jump_D) & ~br_done_q & (BR_WAIT_CYCLES > 0);
  end

  // Sequencer next-state and control decode; mispredict pre-empts any state.
  always_comb begin
    state_d    = state_q;
    br_done_d  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    tmr_dec_s  = 1'b0;
    stall_s    = 1'b0;
    flush_de_s = 1'b0;
    flush_w_s  = 1'b0;
    redirect_s = 1'b0;
    if (mispred_s) begin
      flush_de_s = 1'b1;
      flush_w_s  = FW_MIS;
      redirect_s = 1'b1;
      tmr_load_s = 1'b1;
      tmr_val_s  = FL_INIT;
      state_d    = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_haz_s) begin
            stall_s    = 1'b1;
            flush_de_s = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = LS_INIT;
            state_d    = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : IDLE;
          end else if (br_haz_s) begin
            stall_s    = 1'b1;
            flush_de_s = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = BR_INIT;
            state_d    = (BR_WAIT_CYCLES > 1) ? BR_WAIT : IDLE;
            br_done_d  = (BR_WAIT_CYCLES == 1);
          end else begin
            state_d = IDLE;
          end
        end
        LOAD_STALL, BR_WAIT: begin
          stall_s    = 1'b1;
          flush_de_s = 1'b1;
          if (tmr_zero_s) begin
            state_d   = IDLE;
            br_done_d = (state_q == BR_WAIT);
          end else begin
            tmr_dec_s = 1'b1;
          end
        end
        FLUSH: begin
          flush_de_s = 1'b1;
          if (tmr_zero_s) state_d = IDLE;
          else            tmr_dec_s = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = {CNT_W{1'b0}};
    end else if (stall_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Sequencer and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      br_done_q      <= 1'b0;
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      br_done_q      <= br_done_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Controls are forced low while reset is held, including the combinational triggers.
  assign stall_F      = reset & stall_s;
  assign stall_D      = reset & stall_s;
  assign stall_E      = 1'b0;
  assign stall_W      = 1'b0;
  assign flush_D      = reset & flush_de_s & ~stall_s;
  assign flush_E      = reset & flush_de_s;
  assign flush_W      = reset & flush_w_s;
  assign redirect_F   = reset & redirect_s;
  assign fwd_a_E      = reset & regwe_W & (rd_W != {REG_AW{1'b0}}) & (rd_W == rs1_E);
  assign fwd_b_E      = reset & regwe_W & (rd_W != {REG_AW{1'b0}}) & (rd_W == rs2_E);
  assign busy         = reset & (state_q != IDLE);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hcu_param.sv
// Self-checking bench for hcu_param: three instances with different
// parameter sets share one stimulus stream; directed scenarios check fixed
// expectations and a random phase checks against a cycle-count model.
module tb_hcu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load_E, regwe_W, branch_D, jump_D, branch_E, cond_met_E, perf_clr;
  logic [4:0] rd_E, rs1_D, rs2_D, rs1_E, rs2_E, rd_W;
  logic       stall_F[3], stall_D[3], stall_E[3], stall_W[3], flush_D[3], flush_E[3];
  logic       flush_W[3], redirect_F[3], fwd_a_E[3], fwd_b_E[3], busy[3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;

  int n_checks = 0;
  int n_errors = 0;

  // Instance parameters, mirrored for the model.
  int p_lsc[3] = '{2, 2, 3};
  int p_dep[3] = '{1, 0, 1};
  int p_fc[3]  = '{1, 1, 3};
  int p_fw[3]  = '{1, 1, 0};
  int p_bw[3]  = '{1, 1, 2};
  int p_cw[3]  = '{16, 16, 2};

  // Model: kind 0 none, 1 load stall, 2 flush, 3 branch wait; left = cycles still owed.
  int m_kind[3], m_left[3], m_cnt[3];
  bit m_brdone[3];

  hcu_param u0 (.clk(clk), .reset(reset), .load_E(load_E), .rd_E(rd_E), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_W(rd_W), .regwe_W(regwe_W), .branch_D(branch_D), .jump_D(jump_D),
    .branch_E(branch_E), .cond_met_E(cond_met_E), .perf_clr(perf_clr), .stall_F(stall_F[0]),
    .stall_D(stall_D[0]), .stall_E(stall_E[0]), .stall_W(stall_W[0]), .flush_D(flush_D[0]),
    .flush_E(flush_E[0]), .flush_W(flush_W[0]), .redirect_F(redirect_F[0]), .fwd_a_E(fwd_a_E[0]),
    .fwd_b_E(fwd_b_E[0]), .busy(busy[0]), .stall_cycles(sc0));

  hcu_param #(.LOAD_DEP_CHECK(0)) u1 (.clk(clk), .reset(reset), .load_E(load_E), .rd_E(rd_E),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_W(rd_W), .regwe_W(regwe_W),
    .branch_D(branch_D), .jump_D(jump_D), .branch_E(branch_E), .cond_met_E(cond_met_E),
    .perf_clr(perf_clr), .stall_F(stall_F[1]), .stall_D(stall_D[1]), .stall_E(stall_E[1]),
    .stall_W(stall_W[1]), .flush_D(flush_D[1]), .flush_E(flush_E[1]), .flush_W(flush_W[1]),
    .redirect_F(redirect_F[1]), .fwd_a_E(fwd_a_E[1]), .fwd_b_E(fwd_b_E[1]), .busy(busy[1]),
    .stall_cycles(sc1));

  hcu_param #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .FLUSH_W_ON_MISPRED(0), .BR_WAIT_CYCLES(2),
    .CNT_W(2)) u2 (.clk(clk), .reset(reset), .load_E(load_E), .rd_E(rd_E), .rs1_D(rs1_D),
    .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_W(rd_W), .regwe_W(regwe_W), .branch_D(branch_D),
    .jump_D(jump_D), .branch_E(branch_E), .cond_met_E(cond_met_E), .perf_clr(perf_clr),
    .stall_F(stall_F[2]), .stall_D(stall_D[2]), .stall_E(stall_E[2]), .stall_W(stall_W[2]),
    .flush_D(flush_D[2]), .flush_E(flush_E[2]), .flush_W(flush_W[2]), .redirect_F(redirect_F[2]),
    .fwd_a_E(fwd_a_E[2]), .fwd_b_E(fwd_b_E[2]), .busy(busy[2]), .stall_cycles(sc2));

  // Observed controls: {sF,sD,sE,sW,fD,fE,fW,redir,fwdA,fwdB,busy}
  function automatic logic [10:0] ctl(input int i);
    return {stall_F[i], stall_D[i], stall_E[i], stall_W[i], flush_D[i], flush_E[i], flush_W[i],
            redirect_F[i], fwd_a_E[i], fwd_b_E[i], busy[i]};
  endfunction

  function automatic logic [15:0] get_sc(input int i);
    if (i == 0) return sc0;
    else if (i == 1) return sc1;
    else return {14'd0, sc2};
  endfunction

  function automatic bit m_mis();
    return branch_E && !cond_met_E;
  endfunction

  function automatic bit m_ld(input int i);
    return load_E && (p_dep[i] == 0 || (rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D)));
  endfunction

  function automatic bit m_br(input int i);
    return (branch_D || jump_D) && !m_brdone[i] && p_bw[i] > 0;
  endfunction

  function automatic logic [10:0] exp_ctl(input int i);
    bit st, fd, fe, fw, rf, fa, fb;
    st = 0; fd = 0; fe = 0; fw = 0; rf = 0;
    if (!reset) return 11'd0;
    fa = regwe_W && rd_W != 5'd0 && rd_W == rs1_E;
    fb = regwe_W && rd_W != 5'd0 && rd_W == rs2_E;
    if (m_mis()) begin fd = 1; fe = 1; rf = 1; fw = (p_fw[i] != 0); end
    else if (m_kind[i] == 1 || m_kind[i] == 3) begin st = 1; fe = 1; end
    else if (m_kind[i] == 2) begin fd = 1; fe = 1; end
    else if (m_ld(i) || m_br(i)) begin st = 1; fe = 1; end
    return {st, st, 1'b0, 1'b0, fd, fe, fw, rf, fa, fb, (m_kind[i] != 0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_kind[i] = 0; m_left[i] = 0; m_cnt[i] = 0; m_brdone[i] = 0;
    end
  endtask

  task automatic model_clock();
    bit st, nbd;
    if (!reset) begin model_reset(); return; end
    for (int i = 0; i < 3; i++) begin
      st  = exp_ctl(i)[10];
      nbd = 0;
      if (m_mis()) begin m_kind[i] = 2; m_left[i] = p_fc[i] - 1; end
      else if (m_kind[i] != 0) begin
        m_left[i]--;
        if (m_left[i] == 0 && m_kind[i] == 3) nbd = 1;
      end
      else if (m_ld(i)) begin m_kind[i] = 1; m_left[i] = p_lsc[i] - 1; end
      else if (m_br(i)) begin m_kind[i] = 3; m_left[i] = p_bw[i] - 1; nbd = (m_left[i] == 0); end
      if (m_left[i] == 0) m_kind[i] = 0;
      if (perf_clr) m_cnt[i] = 0;
      else if (st && m_cnt[i] < (1 << p_cw[i]) - 1) m_cnt[i]++;
      m_brdone[i] = nbd;
    end
  endtask

  task automatic idle_inputs();
    load_E = 0; rd_E = 0; rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_W = 0;
    regwe_W = 0; branch_D = 0; jump_D = 0; branch_E = 0; cond_met_E = 0; perf_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1 reset = 1'b0;
    load_E = 1; rd_E = 5'd5; rs1_D = 5'd5; branch_E = 1; regwe_W = 1; rd_W = 5'd3; rs1_E = 5'd3;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ctl(i) !== 11'd0) begin
        n_errors++; $display("FAIL reset_ctl inst%0d got %b exp %b", i, ctl(i), 11'd0);
      end
      n_checks++;
      if (get_sc(i) !== 16'd0) begin
        n_errors++; $display("FAIL reset_cnt inst%0d got %0d exp 0", i, get_sc(i));
      end
    end
    step(); step();
    idle_inputs();
    reset = 1'b1;
    settle();
  endtask

  // Load with true dependency: 2 cycles on u0/u1, 3 on u2; busy lasts one cycle less.
  task automatic test_load_hazard();
    logic [2:0] exp_st[3];
    perf_clr = 1; step(); perf_clr = 0;
    for (int c = 0; c < 4; c++) begin
      load_E = (c == 0); rd_E = 5'd5; rs1_D = 5'd5; rs2_D = 5'd0;
      exp_st[0] = (c < 2) ? 3'b110 : 3'b000;
      exp_st[1] = exp_st[0];
      exp_st[2] = (c < 3) ? 3'b110 : 3'b000;
      if (c >= 1 && c < 2) exp_st[0][0] = 1'b1;
      if (c >= 1 && c < 2) exp_st[1][0] = 1'b1;
      if (c >= 1 && c < 3) exp_st[2][0] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({stall_F[i], stall_D[i], busy[i]} !== exp_st[i] || flush_E[i] !== exp_st[i][2]) begin
          n_errors++; $display("FAIL load_hazard inst%0d cyc%0d got sF/sD/busy=%b fE=%b exp %b",
                               i, c, {stall_F[i], stall_D[i], busy[i]}, flush_E[i], exp_st[i]);
        end
      end
      step();
    end
    n_checks++;
    if (sc0 !== 16'd2) begin
      n_errors++; $display("FAIL load_count got %0d exp 2", sc0);
    end
    settle();
  endtask

  task automatic test_no_dep();
    for (int c = 0; c < 3; c++) begin
      load_E = (c == 0); rd_E = 5'd5; rs1_D = 5'd6; rs2_D = 5'd7;
      @(negedge clk);
      n_checks++;
      if (stall_F[0] !== 1'b0) begin
        n_errors++; $display("FAIL no_dep_checked cyc%0d got %b exp 0", c, stall_F[0]);
      end
      n_checks++;
      if (stall_F[1] !== (c < 2)) begin
        n_errors++; $display("FAIL no_dep_legacy cyc%0d got %b exp %b", c, stall_F[1], (c < 2));
      end
      step();
    end
    settle();
  endtask

  task automatic test_mispred_abort();
    load_E = 1; rd_E = 5'd5; rs1_D = 5'd5;
    step();
    load_E = 0; branch_E = 1; cond_met_E = 0;
    @(negedge clk);
    n_checks++;
    if (ctl(0) !== 11'b0000_1111_001) begin
      n_errors++; $display("FAIL mispred_abort got %b exp %b", ctl(0), 11'b0000_1111_001);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctl(0) !== 11'd0) begin
      n_errors++; $display("FAIL mispred_after got %b exp %b", ctl(0), 11'd0);
    end
    settle();
  endtask

  // branch_D held 4 cycles: u0 (1-cycle wait) 1,0,1,0; u2 (2-cycle wait) 1,1,0,1.
  task automatic test_branch_wait();
    logic [3:0] pat0, pat2;
    pat0 = 4'b1010; pat2 = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      branch_D = 1;
      @(negedge clk);
      n_checks++;
      if (stall_D[0] !== pat0[3-c]) begin
        n_errors++; $display("FAIL branch_wait inst0 cyc%0d got %b exp %b", c, stall_D[0], pat0[3-c]);
      end
      n_checks++;
      if (stall_D[2] !== pat2[3-c]) begin
        n_errors++; $display("FAIL branch_wait inst2 cyc%0d got %b exp %b", c, stall_D[2], pat2[3-c]);
      end
      step();
    end
    settle();
  endtask

  task automatic test_forwarding();
    regwe_W = 1; rd_W = 5'd3; rs1_E = 5'd3; rs2_E = 5'd3;
    @(negedge clk);
    n_checks++;
    if ({fwd_a_E[0], fwd_b_E[0]} !== 2'b11) begin
      n_errors++; $display("FAIL fwd_both got %b exp 11", {fwd_a_E[0], fwd_b_E[0]});
    end
    rd_W = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
    #1;
    n_checks++;
    if ({fwd_a_E[0], fwd_b_E[0]} !== 2'b00) begin
      n_errors++; $display("FAIL fwd_x0 got %b exp 00", {fwd_a_E[0], fwd_b_E[0]});
    end
    settle();
  endtask

  task automatic test_reset_in_flush();
    branch_E = 1; cond_met_E = 0;
    @(negedge clk);
    n_checks++;
    if (ctl(2) !== 11'b0000_1101_000) begin
      n_errors++; $display("FAIL flush_trigger got %b exp %b", ctl(2), 11'b0000_1101_000);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctl(2) !== 11'b0000_1100_001) begin
      n_errors++; $display("FAIL flush_hold got %b exp %b", ctl(2), 11'b0000_1100_001);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (ctl(2) !== 11'd0) begin
      n_errors++; $display("FAIL reset_in_flush got %b exp %b", ctl(2), 11'd0);
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl(2) !== 11'd0) begin
      n_errors++; $display("FAIL after_reset_flush got %b exp %b", ctl(2), 11'd0);
    end
    settle();
  endtask

  // u2 (3-cycle loads, 2-bit counter): loads at c0 and c3 give 5 stall edges by c5.
  task automatic test_perf_saturation();
    perf_clr = 1; step(); perf_clr = 0;
    for (int c = 0; c < 6; c++) begin
      load_E = (c == 0 || c == 3); rd_E = 5'd5; rs1_D = 5'd5;
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (sc2 !== 2'd2) begin
          n_errors++; $display("FAIL perf_mid got %0d exp 2", sc2);
        end
      end else if (c == 5) begin
        n_checks++;
        if (sc2 !== 2'd3) begin
          n_errors++; $display("FAIL perf_sat got %0d exp 3", sc2);
        end
      end else begin
        n_checks = n_checks;
      end
      step();
    end
    idle_inputs();
    perf_clr = 1; step(); perf_clr = 0;
    @(negedge clk);
    n_checks++;
    if (sc2 !== 2'd0) begin
      n_errors++; $display("FAIL perf_clr got %0d exp 0", sc2);
    end
    settle();
  endtask

  task automatic test_random();
    logic [10:0] e;
    reset = 1'b0; step(); reset = 1'b1;
    for (int c = 0; c < 400; c++) begin
      load_E     = ($urandom_range(0, 2) == 0);
      rd_E       = 5'($urandom_range(0, 3));
      rs1_D      = 5'($urandom_range(0, 3));
      rs2_D      = 5'($urandom_range(0, 3));
      rs1_E      = 5'($urandom_range(0, 3));
      rs2_E      = 5'($urandom_range(0, 3));
      rd_W       = 5'($urandom_range(0, 3));
      regwe_W    = ($urandom_range(0, 1) == 1);
      branch_D   = ($urandom_range(0, 3) == 0);
      jump_D     = ($urandom_range(0, 7) == 0);
      branch_E   = ($urandom_range(0, 5) == 0);
      cond_met_E = ($urandom_range(0, 1) == 1);
      perf_clr   = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        e = exp_ctl(i);
        n_checks++;
        if (ctl(i) !== e) begin
          n_errors++; $display("FAIL random_ctl inst%0d cyc%0d got %b exp %b", i, c, ctl(i), e);
        end
        n_checks++;
        if (get_sc(i) !== 16'(m_cnt[i])) begin
          n_errors++; $display("FAIL random_cnt inst%0d cyc%0d got %0d exp %0d", i, c, get_sc(i), m_cnt[i]);
        end
      end
      step();
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_load_hazard();
    test_no_dep();
    test_mispred_abort();
    test_branch_wait();
    test_forwarding();
    test_reset_in_flush();
    test_perf_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hcu_param.md
Name: hcu_param

Overview:
- Parametrised hazard control unit for the F/D/E/W pipeline.
- Generates stall, flush, redirect and forwarding controls from per-stage hazard information.
- Holds an internal sequencer for multi-cycle hazards: load-use stall, mispredict flush and branch-resolve wait. This replaces the external "already branched" flag.
- Adds dependency-checked load stalls, x0-aware forwarding and a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL_CYCLES, 2, cycles of stall per load hazard (>=1).
- LOAD_DEP_CHECK, 1, 1 = stall only on a true rd/rs match; 0 = stall on every load in E (legacy).
- FLUSH_CYCLES, 1, cycles flush_D/flush_E are held on a mispredict (>=1).
- FLUSH_W_ON_MISPRED, 1, also pulse flush_W on the mispredict trigger cycle.
- BR_WAIT_CYCLES, 1, decode hold cycles for a branch/jump in D (0 disables).
- CNT_W, 16, perf counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- load_E  in  1  load instruction valid in Execute
- rd_E  in  REG_AW  Execute destination
- rs1_D, rs2_D  in  REG_AW  Decode sources
- rs1_E, rs2_E  in  REG_AW  Execute sources
- rd_W  in  REG_AW  Writeback destination
- regwe_W  in  1  Writeback register write enable
- branch_D, jump_D  in  1  control-flow instruction in Decode
- branch_E  in  1  branch in Execute
- cond_met_E  in  1  branch condition result
- perf_clr  in  1  synchronous perf counter clear
- stall_F, stall_D, stall_E, stall_W  out  1  stage hold
- flush_D, flush_E, flush_W  out  1  stage bubble
- redirect_F  out  1  PC redirect pulse
- fwd_a_E, fwd_b_E  out  1  select W result for operand A/B
- busy  out  1  sequencer not IDLE
- stall_cycles  out  CNT_W  saturating count of stall_F cycles

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters=0, br_done=0, stall_cycles=0. All control outputs are 0 while in reset.
- stall_E and stall_W are tied 0. They exist only for interface compatibility.
- States (hcu_pkg::hcu_state_t): IDLE, LOAD_STALL, FLUSH, BR_WAIT. A down-counter `remain` runs alongside the state.
- Trigger conditions:
  - mispred = branch_E & ~cond_met_E.
  - ld_haz = load_E & (LOAD_DEP_CHECK==0 | (rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D))).
  - br_haz = (branch_D | jump_D) & ~br_done & BR_WAIT_CYCLES>0.
- Priority, evaluated in every state: mispred > ld_haz (IDLE only) > br_haz (IDLE only).
- Mispred trigger cycle (combinational, same cycle):
  - flush_D=1, flush_E=1, redirect_F=1, flush_W=FLUSH_W_ON_MISPRED, stall_F=0.
  - Next state = FLUSH with remain=FLUSH_CYCLES-2 if FLUSH_CYCLES>1, else IDLE.
  - In FLUSH: flush_D=flush_E=1, redirect_F=0.
- Mispred in LOAD_STALL or BR_WAIT aborts that sequence immediately and takes the mispred path.
- Load trigger (IDLE):
  - stall_F=stall_D=1, flush_E=1 in the same cycle.
  - Next state = LOAD_STALL with remain=LOAD_STALL_CYCLES-2, or IDLE if LOAD_STALL_CYCLES==1.
  - The same outputs are held in LOAD_STALL.
- Branch trigger (IDLE):
  - stall_F=stall_D=1, flush_E=1.
  - Next state = BR_WAIT with remain=BR_WAIT_CYCLES-2, or IDLE if the value is 1. The same outputs are held in BR_WAIT.
  - On every exit to IDLE from a branch wait, br_done is set for exactly one cycle. This suppresses retrigger by the same, now-released instruction.
- Each non-IDLE state returns to IDLE on the edge where remain==0; otherwise remain decrements.
- Total asserted cycles per event is exactly the parameter value.
- Forwarding (combinational, independent of state):
  - fwd_a_E = regwe_W & rd_W!=0 & rd_W==rs1_E. fwd_b_E is the same with rs2_E.
  - Both operands may forward simultaneously.
- busy = (state != IDLE).
- stall_cycles increments on each clock with stall_F=1 and holds at 2^CNT_W-1.
  - perf_clr forces 0. perf_clr wins over increment.
- Asserting reset mid-sequence aborts to IDLE asynchronously. Outputs drop in the same cycle.

Decomposition:
- hcu_pkg: hcu_state_t enum, function for counter width ($clog2 of max(LOAD_STALL_CYCLES, FLUSH_CYCLES, BR_WAIT_CYCLES)+1), parameter legality checks.
- Sub-module hcu_stall_timer: loadable down-counter with a zero flag. Instantiated once; shared by all states.

Test Plan:
- Load hazard: load_E=1, rd_E=5, rs1_D=5 (defaults) -> stall_F/stall_D/flush_E high for exactly 2 cycles, busy high for 1 cycle, stall_cycles=2.
- No dependency: load_E=1, rd_E=5, rs1_D=6, rs2_D=7 with LOAD_DEP_CHECK=1 -> no stall. Same stimulus with LOAD_DEP_CHECK=0 -> 2-cycle stall.
- Mispredict aborts load stall: mispred asserted in the 2nd LOAD_STALL cycle -> that cycle shows flush_D=flush_E=flush_W=redirect_F=1, stall_F=0; next cycle IDLE with all outputs 0.
- Branch wait: branch_D held high for 4 cycles -> stall_D high for 1 cycle, br_done blocks the next cycle, and a re-trigger occurs only on the cycle after that.
- Forwarding: regwe_W=1, rd_W=3, rs1_E=3, rs2_E=3 -> fwd_a_E=fwd_b_E=1. With rd_W=0 and rs1_E=0 -> both 0.
- Reset in FLUSH (FLUSH_CYCLES=3), plus perf counter saturation: reset low in FLUSH -> outputs 0 immediately, state IDLE. With CNT_W=2 and 5 stall cycles -> stall_cycles=3; perf_clr -> 0.
